// File: rtl/msp430_spram_initiator.sv
// +----------------------------------------------------------------------------+
// | msp430_spram_initiator: valid/ready request/response bridge to a bb_ext    |
// | single-port RAM, with in-order read return through a credit-gated FIFO.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module msp430_spram_initiator #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic          req_we_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic [AW-1:0] spram_addr_o,
  output logic [DW-1:0] spram_din_o,
  output logic          spram_en_o,
  output logic          spram_we_o,
  input  logic [DW-1:0] spram_dout_i,
  output logic          busy_o
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("msp430_spram_initiator: RD_LATENCY must be in 1..4");
    end
    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("msp430_spram_initiator: RSP_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [CW-1:0]     r_reserved;
  logic [CW-1:0]     w_reserved_nxt;
  logic              r_ready;
  logic [RD_LATENCY:0] r_tag;
  logic [DW-1:0]     r_fifo [RSP_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic w_accept;
  logic w_rd_accept;
  logic w_push;
  logic w_pop;
  logic w_full;

  assign w_accept    = req_valid_i && r_ready;
  assign w_rd_accept = w_accept && !req_we_i;
  assign w_push      = r_tag[RD_LATENCY];
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign w_full      = (r_count == CW'(RSP_DEPTH));

  assign req_ready_o = r_ready;
  assign rsp_valid_o = (r_count != '0);
  assign rsp_rdata_o = r_fifo[r_rptr];
  assign busy_o      = (r_reserved != '0) || spram_en_o;

  // Credits cover every read from acceptance until its response is popped,
  // so the FIFO always has room for data already in flight.
  always_comb begin
    w_reserved_nxt = r_reserved;
    if (w_rd_accept && !w_pop) begin
      w_reserved_nxt = r_reserved + 1'b1;
    end else if (!w_rd_accept && w_pop) begin
      w_reserved_nxt = r_reserved - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reserved   <= '0;
      r_ready      <= 1'b0;
      spram_en_o   <= 1'b0;
      spram_we_o   <= 1'b0;
      spram_addr_o <= '0;
      spram_din_o  <= '0;
      r_tag        <= '0;
    end else begin
      r_reserved <= w_reserved_nxt;
      r_ready    <= (w_reserved_nxt < CW'(RSP_DEPTH));
      spram_en_o <= w_accept;
      spram_we_o <= w_accept && req_we_i;
      if (w_accept) begin
        spram_addr_o <= req_addr_i;
        spram_din_o  <= req_wdata_i;
      end
      r_tag <= {r_tag[RD_LATENCY-1:0], w_rd_accept};
    end
  end

  // First-word fall-through response buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= spram_dout_i;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_push && w_full));

endmodule

`default_nettype wire

// File: tb/tb_msp430_spram_initiator.sv
// Bench for msp430_spram_initiator: directed vectors, corner sequences and
// randomized traffic against a behavioural memory/queue model.
`default_nettype none

module tb_msp430_spram_initiator;

  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        req_valid_i, req_we_i, rsp_ready_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, rsp_valid_o, spram_en_o, spram_we_o, busy_o;
  logic [31:0] rsp_rdata_o, spram_addr_o, spram_din_o, spram_dout_i;

  logic        req_valid3, req_we3, rsp_ready3;
  logic [31:0] req_addr3, req_wdata3;
  logic        req_ready3, rsp_valid3, spram_en3, spram_we3, busy3;
  logic [31:0] rsp_rdata3, spram_addr3, spram_din3, spram_dout3;

  int n_checks = 0;
  int n_fail   = 0;

  msp430_spram_initiator #(.AW(32), .DW(32), .RD_LATENCY(LAT), .RSP_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_we_i(req_we_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .spram_addr_o(spram_addr_o), .spram_din_o(spram_din_o), .spram_en_o(spram_en_o),
    .spram_we_o(spram_we_o), .spram_dout_i(spram_dout_i), .busy_o(busy_o)
  );

  msp430_spram_initiator #(.AW(32), .DW(32), .RD_LATENCY(3), .RSP_DEPTH(DEPTH)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_addr_i(req_addr3),
    .req_wdata_i(req_wdata3), .req_we_i(req_we3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_rdata_o(rsp_rdata3),
    .spram_addr_o(spram_addr3), .spram_din_o(spram_din3), .spram_en_o(spram_en3),
    .spram_we_o(spram_we3), .spram_dout_i(spram_dout3), .busy_o(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPRAM models: preload mem[a] = a while in reset, read data after LAT edges.
  logic [31:0] mem  [256];
  logic [31:0] mem3 [256];
  logic [31:0] dpipe  [LAT];
  logic [31:0] dpipe3 [3];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (spram_en_o && spram_we_o) begin
      mem[spram_addr_o[7:0]] <= spram_din_o;
    end
    dpipe[0] <= (spram_en_o && !spram_we_o) ? mem[spram_addr_o[7:0]] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign spram_dout_i = dpipe[LAT-1];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 32'(i);
    end else if (spram_en3 && spram_we3) begin
      mem3[spram_addr3[7:0]] <= spram_din3;
    end
    dpipe3[0] <= (spram_en3 && !spram_we3) ? mem3[spram_addr3[7:0]] : 32'hBAD0_BAD0;
    for (int i = 1; i < 3; i++) dpipe3[i] <= dpipe3[i-1];
  end
  assign spram_dout3 = dpipe3[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a flat memory updated in issue order and a queue of
  // read results awaiting return; the queue length is the outstanding credit.
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];
  logic        alive;
  logic        m_en, m_we, m_acc;
  logic [31:0] m_addr, m_din;

  always @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
      m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
    end else begin
      check("mon_ready", req_ready_o, alive && (exp_q.size() < DEPTH));
      check("mon_en", spram_en_o, m_en);
      check("mon_we", spram_we_o, m_we);
      check("mon_addr", spram_addr_o, m_addr);
      check("mon_din", spram_din_o, m_din);
      check("mon_busy", busy_o, (exp_q.size() != 0) || m_en);
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) check("mon_spurious_rsp", 1, 0);
        else                   check("mon_rdata", rsp_rdata_o, exp_q[0]);
      end
      m_acc = req_valid_i && alive && (exp_q.size() < DEPTH);
      if (rsp_valid_o && rsp_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
      if (m_acc) begin
        if (req_we_i) ref_mem[req_addr_i[7:0]] = req_wdata_i;
        else          exp_q.push_back(ref_mem[req_addr_i[7:0]]);
        m_addr = req_addr_i;
        m_din  = req_wdata_i;
      end
      m_en = m_acc;
      m_we = m_acc && req_we_i;
    end
  end

  typedef struct {
    logic        vld, we;
    logic [31:0] addr, wdata;
    logic        rrdy;
    logic        e_ready, e_en, e_we;
    logic [31:0] e_addr, e_din;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_busy;
  } vec_t;

  task automatic idle();
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b1;
  endtask

  task automatic drain(input string name);
    int c = 0;
    idle();
    while ((exp_q.size() != 0 || busy_o) && c < 50) begin
      step();
      c++;
    end
    check(name, c < 50, 1);
  endtask

  vec_t tbl [5];
  int   n_acc;
  logic acc_now;
  int   c3;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0};

    rst = 1'b0;
    idle();
    req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b1;
    repeat (3) step();
    check("rst_ready", req_ready_o, 0);
    check("rst_en", spram_en_o, 0);
    check("rst_we", spram_we_o, 0);
    check("rst_addr", spram_addr_o, 0);
    check("rst_din", spram_din_o, 0);
    check("rst_rvalid", rsp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    #1 rst = 1'b1;
    step();
    check("release_ready", req_ready_o, 1);
    check("release_ready3", req_ready3, 1);

    // Write then read of the same address, cycle by cycle.
    foreach (tbl[i]) begin
      req_valid_i = tbl[i].vld; req_we_i = tbl[i].we; req_addr_i = tbl[i].addr;
      req_wdata_i = tbl[i].wdata; rsp_ready_i = tbl[i].rrdy;
      step();
      check($sformatf("vec%0d_ready", i), req_ready_o, tbl[i].e_ready);
      check($sformatf("vec%0d_en", i), spram_en_o, tbl[i].e_en);
      check($sformatf("vec%0d_we", i), spram_we_o, tbl[i].e_we);
      check($sformatf("vec%0d_addr", i), spram_addr_o, tbl[i].e_addr);
      check($sformatf("vec%0d_din", i), spram_din_o, tbl[i].e_din);
      check($sformatf("vec%0d_rvalid", i), rsp_valid_o, tbl[i].e_rvalid);
      if (tbl[i].e_rvalid) check($sformatf("vec%0d_rdata", i), rsp_rdata_o, tbl[i].e_rdata);
      check($sformatf("vec%0d_busy", i), busy_o, tbl[i].e_busy);
    end

    // Six reads under backpressure: only four credits.
    idle();
    rsp_ready_i = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid_i = (n_acc < 6); req_addr_i = 32'(n_acc);
      acc_now = req_valid_i && req_ready_o;
      step();
      if (acc_now) n_acc++;
    end
    check("bp_accepted", n_acc, 4);
    check("bp_ready_low", req_ready_o, 0);
    rsp_ready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check($sformatf("bp_rvalid%0d", j), rsp_valid_o, 1);
      check($sformatf("bp_rdata%0d", j), rsp_rdata_o, 32'(j));
      req_valid_i = (n_acc < 6); req_addr_i = 32'(n_acc);
      acc_now = req_valid_i && req_ready_o;
      step();
      if (acc_now) n_acc++;
    end
    check("bp_total", n_acc, 6);
    drain("bp_drain");

    // Full FIFO with continuous requests: one response per cycle.
    rsp_ready_i = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid_i = (n_acc < 4); req_addr_i = 32'(8 + n_acc);
      acc_now = req_valid_i && req_ready_o;
      step();
      if (acc_now) n_acc++;
    end
    check("full_fill", n_acc, 4);
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'($urandom_range(0, 31));
      check($sformatf("full_rvalid%0d", k), rsp_valid_o, 1);
      if (k > 0) check($sformatf("full_ready%0d", k), req_ready_o, 1);
      step();
    end
    drain("full_drain");

    // RD_LATENCY=3 instance: read, then a write to the same address.
    req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 32'h20;
    step();
    check("lat3_rvalid_k0", rsp_valid3, 0);
    req_we3 = 1'b1; req_wdata3 = 32'h12345678;
    for (int c = 1; c <= 4; c++) begin
      step();
      req_valid3 = 1'b0;
      check($sformatf("lat3_rvalid_k%0d", c), rsp_valid3, c == 4);
    end
    check("lat3_rdata", rsp_rdata3, 32'h20);
    step();
    check("lat3_popped", rsp_valid3, 0);
    req_valid3 = 1'b1; req_we3 = 1'b0;
    step();
    req_valid3 = 1'b0;
    c3 = 0;
    while (!rsp_valid3 && c3 < 10) begin
      step();
      c3++;
    end
    check("lat3_second_timeout", c3 < 10, 1);
    check("lat3_second_rdata", rsp_rdata3, 32'h12345678);

    // Random mixed traffic.
    for (int n = 0; n < 3000; n++) begin
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_we_i    = ($urandom_range(0, 2) == 0);
      req_addr_i  = 32'($urandom_range(0, 15));
      req_wdata_i = $urandom;
      rsp_ready_i = ((n / 200) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand_drain");

    // Asynchronous reset with two reads in flight and one buffered.
    rsp_ready_i = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'(a);
      step();
    end
    req_valid_i = 1'b0;
    check("mid_buffered", rsp_valid_o, 1);
    #1 rst = 1'b0;
    #1;
    check("mid_ready", req_ready_o, 0);
    check("mid_en", spram_en_o, 0);
    check("mid_we", spram_we_o, 0);
    check("mid_addr", spram_addr_o, 0);
    check("mid_din", spram_din_o, 0);
    check("mid_rvalid", rsp_valid_o, 0);
    check("mid_rdata", rsp_rdata_o, 0);
    check("mid_busy", busy_o, 0);
    step();
    step();
    #1 rst = 1'b1;
    rsp_ready_i = 1'b1;
    step();
    check("post_ready", req_ready_o, 1);
    check("post_busy", busy_o, 0);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("post_no_rsp%0d", c), rsp_valid_o, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
